// File: rtl/dvi_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_timing_pkg
//  Purpose  : Shared definitions for the DVI timing generator: default
//             640x480@60 timing constants, the sequencing FSM state type and
//             the TMDS channel control-word mapping.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dvi_timing_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_lead     = 2;
  localparam int c_cnt_w    = 10;

  // Sequencing FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Green and red channels carry no control information in DVI.
  localparam logic [1:0] c_ctrl1_word = 2'b00;
  localparam logic [1:0] c_ctrl2_word = 2'b00;

  // Blue-channel control word {vsync, hsync} at line level, given whether
  // each sync is logically active and its active polarity.
  function automatic logic [1:0] ctrl0_word(input logic vsync_act,
                                            input logic hsync_act,
                                            input logic vs_pol,
                                            input logic hs_pol);
    return {(vsync_act ? vs_pol : ~vs_pol), (hsync_act ? hs_pol : ~hs_pol)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_axis_counter
//  Purpose  : One timing axis (horizontal or vertical). Counts 0..TOTAL-1
//             and wraps, and decodes the active and sync regions.
//  Ports    : i_clk, i_rstn   - clock, asynchronous active-low reset
//             i_load          - load o_count with i_load_val (wins over advance)
//             i_load_val      - value loaded by i_load
//             i_advance       - step the count by one, wrapping at TOTAL-1
//             o_count         - current count
//             o_wrap          - count is at TOTAL-1 (next advance wraps)
//             o_active        - count < ACTIVE
//             o_sync          - count in [ACTIVE+FP, ACTIVE+FP+SYNC)
//  Revision : 1.0 - initial release
// ============================================================================
module dvi_axis_counter #(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int CNT_W  = 10
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_advance,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  localparam logic [CNT_W-1:0] c_last       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] c_active     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] c_sync_first = CNT_W'(ACTIVE + FP);
  // Inclusive upper bound so the constant never needs TOTAL itself, which
  // may not fit in CNT_W bits when TOTAL == 2**CNT_W.
  localparam logic [CNT_W-1:0] c_sync_last  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_advance) begin
      r_count <= (r_count == c_last) ? '0 : (r_count + c_one);
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = (r_count == c_last);
  assign o_active = (r_count < c_active);
  assign o_sync   = (r_count >= c_sync_first) && (r_count <= c_sync_last);

endmodule
`default_nettype wire

// File: rtl/dvi_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_timing_gen
//  Purpose  : Video timing controller for the three TMDS channel encoders.
//             Generates DE, the channel control words ({vsync,hsync} on the
//             blue channel), pixel coordinates, a look-ahead fetch strobe and
//             a frame-start pulse. Starts and stops only on frame boundaries.
//             All outputs are registered, one cycle behind the counters.
//  Ports    : i_clk          - pixel clock
//             i_rstn         - asynchronous active-low reset
//             i_en           - run request (level)
//             o_de           - data enable
//             o_ctrl0        - blue ctrl {vsync, hsync}
//             o_ctrl1/2      - green/red ctrl, constant 2'b00
//             o_x, o_y       - pixel coordinate while o_de=1, else 0
//             o_fetch        - o_de will be high LEAD cycles later
//             o_frame_start  - pulse with pixel (0,0)
//             o_busy         - engine not idle
//  Revision : 1.0 - initial release
// ============================================================================
module dvi_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = c_lead,
  parameter int CNT_W    = c_cnt_w
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  output logic             o_de,
  output logic [1:0]       o_ctrl0,
  output logic [1:0]       o_ctrl1,
  output logic [1:0]       o_ctrl2,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_fetch,
  output logic             o_frame_start,
  output logic             o_busy
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Start point: front porch of the last blanking line, so the fetch window
  // ahead of pixel (0,0) is always fully available.
  localparam logic [CNT_W-1:0] c_h_load     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_load     = CNT_W'(c_v_total - 1);
  localparam logic [CNT_W-1:0] c_h_act      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_act      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_lead_w     = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] c_la_thresh  = CNT_W'(c_h_total - LEAD);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [1:0]       c_ctrl0_idle = ctrl0_word(1'b0, 1'b0, VS_POL, HS_POL);

  state_t           r_state;
  logic             r_de;
  logic [1:0]       r_ctrl0;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_fetch;
  logic             r_frame_start;
  logic             r_busy;

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_active;
  logic             w_v_active;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_load;
  logic             w_advance;
  logic             w_frame_end;
  logic             w_pix_active;

  // Counters run in RUN and DRAIN (including the edge that returns to IDLE,
  // which leaves them at 0,0) and are loaded on the IDLE->RUN edge.
  assign w_load      = (r_state == ST_IDLE) && i_en;
  assign w_advance   = (r_state != ST_IDLE);
  assign w_frame_end = w_h_wrap && w_v_wrap;

  dvi_axis_counter #(
    .TOTAL  (c_h_total),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load),
    .i_load_val (c_h_load),
    .i_advance  (w_advance),
    .o_count    (w_hcnt),
    .o_wrap     (w_h_wrap),
    .o_active   (w_h_active),
    .o_sync     (w_h_sync)
  );

  dvi_axis_counter #(
    .TOTAL  (c_v_total),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load),
    .i_load_val (c_v_load),
    .i_advance  (w_advance && w_h_wrap),
    .o_count    (w_vcnt),
    .o_wrap     (w_v_wrap),
    .o_active   (w_v_active),
    .o_sync     (w_v_sync)
  );

  assign w_pix_active = w_h_active && w_v_active;

  // Look-ahead position LEAD counts ahead of the current one. LEAD never
  // exceeds the horizontal blanking, so at most one line wrap is crossed.
  logic             w_la_hwrap;
  logic [CNT_W-1:0] w_la_h;
  logic [CNT_W-1:0] w_la_v;
  logic             w_la_next_frame;
  logic             w_la_active;

  assign w_la_hwrap      = (w_hcnt >= c_la_thresh);
  assign w_la_h          = w_la_hwrap ? (w_hcnt - c_la_thresh) : (w_hcnt + c_lead_w);
  assign w_la_v          = !w_la_hwrap ? w_vcnt : (w_v_wrap ? '0 : (w_vcnt + c_one));
  assign w_la_next_frame = w_la_hwrap && w_v_wrap;
  assign w_la_active     = (w_la_h < c_h_act) && (w_la_v < c_v_act);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= ST_IDLE;
      r_de          <= 1'b0;
      r_ctrl0       <= c_ctrl0_idle;
      r_x           <= '0;
      r_y           <= '0;
      r_fetch       <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_en) r_state <= ST_RUN;
        ST_RUN:   if (!i_en) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (i_en)             r_state <= ST_RUN;
          else if (w_frame_end) r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase

      if (r_state == ST_IDLE) begin
        r_de          <= 1'b0;
        r_ctrl0       <= c_ctrl0_idle;
        r_x           <= '0;
        r_y           <= '0;
        r_fetch       <= 1'b0;
        r_frame_start <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        r_de          <= w_pix_active;
        r_ctrl0       <= ctrl0_word(w_v_sync, w_h_sync, VS_POL, HS_POL);
        r_x           <= w_pix_active ? w_hcnt : '0;
        r_y           <= w_pix_active ? w_vcnt : '0;
        // While draining, the next frame will never be shown, so pixels
        // beyond the frame end are not requested.
        r_fetch       <= w_la_active && !((r_state == ST_DRAIN) && w_la_next_frame);
        r_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
        r_busy        <= 1'b1;
      end
    end
  end

  assign o_de          = r_de;
  assign o_ctrl0       = r_ctrl0;
  assign o_ctrl1       = c_ctrl1_word;
  assign o_ctrl2       = c_ctrl2_word;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_fetch       = r_fetch;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dvi_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvi_timing_gen
//  Purpose  : Self-checking bench for dvi_timing_gen using a reduced timing
//             (16x9 totals) so whole frames run quickly. A cycle model pushes
//             expected outputs into a scoreboard queue at each clock edge;
//             they are popped and compared against the DUT 1 time unit later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvi_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int LEAD = 2, CW = 6;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 9
  localparam int FR = HT * VT;            // 144

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          de;
  logic [1:0]    ctrl0, ctrl1, ctrl2;
  logic [CW-1:0] x, y;
  logic          fetch, fs, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic          de;
    logic [1:0]    ctrl0;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fetch;
    logic          fs;
    logic          busy;
  } exp_t;

  exp_t sb[$];

  // Reference model state: mode 0=idle 1=run 2=drain
  int m_mode = 0;
  int m_h    = 0;
  int m_v    = 0;

  dvi_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1'b0), .VS_POL (1'b0), .LEAD (LEAD), .CNT_W (CW)
  ) u_dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_en          (en),
    .o_de          (de),
    .o_ctrl0       (ctrl0),
    .o_ctrl1       (ctrl1),
    .o_ctrl2       (ctrl2),
    .o_x           (x),
    .o_y           (y),
    .o_fetch       (fetch),
    .o_frame_start (fs),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs at an edge, from the model state before that edge.
  function automatic exp_t model_out();
    exp_t e;
    int   p;
    logic hs_a, vs_a;
    e       = '0;
    e.ctrl0 = 2'b11;
    if (m_mode != 0) begin
      e.busy = 1'b1;
      e.de   = (m_h < HA) && (m_v < VA);
      if (e.de) begin
        e.x = CW'(m_h);
        e.y = CW'(m_v);
      end
      hs_a    = (m_h >= HA + HF) && (m_h < HA + HF + HS);
      vs_a    = (m_v >= VA + VF) && (m_v < VA + VF + VS);
      e.ctrl0 = {~vs_a, ~hs_a};
      e.fs    = (m_h == 0) && (m_v == 0);
      p       = m_v * HT + m_h + LEAD;
      if (m_mode == 2 && p >= FR) e.fetch = 1'b0;
      else begin
        p       = p % FR;
        e.fetch = ((p % HT) < HA) && ((p / HT) < VA);
      end
    end
    return e;
  endfunction

  task automatic model_step();
    logic fe;
    if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_h = HA; m_v = VT - 1; end
    end else begin
      fe  = (m_h == HT - 1) && (m_v == VT - 1);
      m_h = m_h + 1;
      if (m_h == HT) begin m_h = 0; m_v = (m_v + 1) % VT; end
      if (m_mode == 1) begin
        if (!en) m_mode = 2;
      end else begin
        if (en) m_mode = 1;
        else if (fe) m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    exp_t e, g;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      m_mode = 0; m_h = 0; m_v = 0;
    end
    e = model_out();
    sb.push_back(e);
    if (rstn) model_step();
    #1;
    g = sb.pop_front();
    check_val("de",    32'(de),    32'(g.de));
    check_val("ctrl0", 32'(ctrl0), 32'(g.ctrl0));
    check_val("ctrl1", 32'(ctrl1), 32'd0);
    check_val("ctrl2", 32'(ctrl2), 32'd0);
    check_val("x",     32'(x),     32'(g.x));
    check_val("y",     32'(y),     32'(g.y));
    check_val("fetch", 32'(fetch), 32'(g.fetch));
    check_val("fstart",32'(fs),    32'(g.fs));
    check_val("busy",  32'(busy),  32'(g.busy));
  endtask

  initial begin
    int e_cyc, de_cyc, fetch_cyc, fs_prev, n;
    int de_cnt, hs_cnt, vs_cnt, rises, rise1, rise2;
    logic prev_de, seen, saw_last;
    int fetch_after;

    // Reset, then 1000 idle cycles with i_en=0
    repeat (3) tick();
    rstn = 1'b1;
    repeat (1000) tick();
    check_val("idle_busy",  32'(busy),  32'd0);
    check_val("idle_de",    32'(de),    32'd0);
    check_val("idle_fetch", 32'(fetch), 32'd0);
    check_val("idle_ctrl0", 32'(ctrl0), 32'd3);

    // Start: DE rises HT-HA+1 edges after the sampling edge, fetch LEAD earlier
    en = 1'b1;
    tick();
    e_cyc = cyc; de_cyc = -1; fetch_cyc = -1;
    for (int i = 0; i < 3 * HT; i++) begin
      tick();
      if (fetch && fetch_cyc < 0) fetch_cyc = cyc;
      if (de) begin de_cyc = cyc; break; end
    end
    check_val("de_rise_lat",    32'(de_cyc - e_cyc),    32'(HT - HA + 1));
    check_val("fetch_rise_lat", 32'(fetch_cyc - e_cyc), 32'(HT - HA + 1 - LEAD));
    check_val("first_fs",       32'(fs),                32'd1);
    check_val("first_xy",       32'({x, y}),            32'd0);

    // Two steady frames: per-line and per-frame counts and periods
    fs_prev = cyc; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; rises = 0;
    rise1 = 0; rise2 = 0; prev_de = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (de) de_cnt++;
      if (!ctrl0[0]) hs_cnt++;
      if (!ctrl0[1]) vs_cnt++;
      if (de && !prev_de) begin
        rises++;
        if (rises == 1) rise1 = cyc;
        if (rises == 2) rise2 = cyc;
      end
      prev_de = de;
      if (fs) begin
        check_val("frame_period", 32'(cyc - fs_prev), 32'(FR));
        fs_prev = cyc;
      end
    end
    check_val("de_cycles",    32'(de_cnt), 32'(2 * HA * VA));
    check_val("hsync_cycles", 32'(hs_cnt), 32'(2 * VT * HS));
    check_val("vsync_cycles", 32'(vs_cnt), 32'(2 * VS * HT));
    check_val("line_period",  32'(rise2 - rise1), 32'(HT));
    check_val("de_lines",     32'(rises), 32'(2 * VA));

    // Drop i_en mid-frame at line 2: frame completes, then idle
    seen = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (de && y == CW'(2) && x == '0) begin seen = 1'b1; break; end
    end
    check_val("reach_line2", 32'(seen), 32'd1);
    en = 1'b0;
    saw_last = 1'b0; fetch_after = 0; seen = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (saw_last && fetch) fetch_after++;
      if (de && x == CW'(HA - 1) && y == CW'(VA - 1)) saw_last = 1'b1;
      if (!busy) begin seen = 1'b1; break; end
    end
    check_val("drain_to_idle",    32'(seen),        32'd1);
    check_val("saw_last_pixel",   32'(saw_last),    32'd1);
    check_val("fetch_after_last", 32'(fetch_after), 32'd0);
    repeat (20) tick();

    // Restart; drop and re-raise i_en within one frame, timing unchanged
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (fs) begin seen = 1'b1; break; end
    end
    check_val("restart_fs", 32'(seen), 32'd1);
    fs_prev = cyc;
    repeat (30) tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    seen = 1'b0; n = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (fs) begin seen = 1'b1; n = cyc - fs_prev; break; end
    end
    check_val("reraise_fs",     32'(seen), 32'd1);
    check_val("reraise_period", 32'(n),    32'(FR));

    // Asynchronous reset at line 1: outputs forced within the same cycle
    seen = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (de && y == CW'(1)) begin seen = 1'b1; break; end
    end
    check_val("reach_line1", 32'(seen), 32'd1);
    #1;
    rstn = 1'b0;
    en   = 1'b0;
    #1;
    check_val("arst_de",    32'(de),    32'd0);
    check_val("arst_busy",  32'(busy),  32'd0);
    check_val("arst_fetch", 32'(fetch), 32'd0);
    check_val("arst_ctrl0", 32'(ctrl0), 32'd3);
    check_val("arst_xy",    32'({x, y}), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
